time_adj_ctrl: RTL

Controller that sequences the calendar's chain of three dual-digit counters (seconds, minutes, hours). It generates the 1 Hz advance trigger into the seconds pair and runs the MODE/UP/DOWN front-panel edit state machine. It drives each counter pair's active-low digit select and its single-cycle up/down adjust pulses. It sits between the debounced key block and the counter chain, and also feeds the display blink logic.

---
 rtl/time_adj_pkg.sv | 40 ++++
 rtl/time_adj_ctrl_if.sv | 26 ++
 rtl/time_adj_ctrl_key_repeat.sv | 65 ++++++
 rtl/time_adj_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/time_adj_pkg.sv
// Shared types and constants for the time-adjust controller and its key path.
package time_adj_pkg;

   typedef enum logic [2:0] {RUN, SEC_U, SEC_T, MIN_U, MIN_T, HR_U, HR_T} state_e;

   typedef enum logic [1:0] {SEC, MIN, HR} field_e;

   localparam logic [1:0] SEL_IDLE  = 2'b11;
   localparam logic [1:0] SEL_UNITS = 2'b10;
   localparam logic [1:0] SEL_TENS  = 2'b01;

   function automatic state_e next_state(state_e s);
      case (s)
         RUN:     return SEC_U;
         SEC_U:   return SEC_T;
         SEC_T:   return MIN_U;
         MIN_U:   return MIN_T;
         MIN_T:   return HR_U;
         HR_U:    return HR_T;
         default: return RUN;
      endcase
   endfunction

   // Active-low digit select of field f while the editor sits in state s.
   function automatic logic [1:0] sel_for(state_e s, field_e f);
      logic [1:0] sel;
      sel = SEL_IDLE;
      case (s)
         SEC_U:   if (f == SEC) sel = SEL_UNITS;
         SEC_T:   if (f == SEC) sel = SEL_TENS;
         MIN_U:   if (f == MIN) sel = SEL_UNITS;
         MIN_T:   if (f == MIN) sel = SEL_TENS;
         HR_U:    if (f == HR)  sel = SEL_UNITS;
         HR_T:    if (f == HR)  sel = SEL_TENS;
         default: sel = SEL_IDLE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/time_adj_ctrl_if.sv
// Key inputs and counter-chain / display outputs of the time-adjust controller.
interface time_adj_ctrl_if;

   logic       I_KEY_MODE;
   logic       I_KEY_UP;
   logic       I_KEY_DOWN;
   logic       O_TRIG_F;
   logic       O_ADJ_UP;
   logic       O_ADJ_DOWN;
   logic [1:0] O_SEL_SEC;
   logic [1:0] O_SEL_MIN;
   logic [1:0] O_SEL_HOUR;
   logic       O_EDIT;
   logic       O_BLINK;

   modport master (
      input  I_KEY_MODE, I_KEY_UP, I_KEY_DOWN,
      output O_TRIG_F, O_ADJ_UP, O_ADJ_DOWN, O_SEL_SEC, O_SEL_MIN, O_SEL_HOUR, O_EDIT, O_BLINK
   );

   modport slave (
      output I_KEY_MODE, I_KEY_UP, I_KEY_DOWN,
      input  O_TRIG_F, O_ADJ_UP, O_ADJ_DOWN, O_SEL_SEC, O_SEL_MIN, O_SEL_HOUR, O_EDIT, O_BLINK
   );

endinterface

// File: rtl/time_adj_ctrl_key_repeat.sv
// One adjust key: input register, rising-edge pulse, hold delay and auto-repeat.
module key_repeat #(
   parameter int unsigned PAR_HOLD_CYC = 25000000,
   parameter int unsigned PAR_RPT_CYC  = 5000000
) (
   input  logic I_SYS_CLK,
   input  logic I_EXT_RST,
   input  logic key,
   input  logic clr,
   output logic pulse,
   output logic key_edge,
   output logic key_level
);

   localparam int unsigned HOLD_W = $clog2(PAR_HOLD_CYC + 1);
   localparam int unsigned RPT_W  = (PAR_RPT_CYC > 1) ? $clog2(PAR_RPT_CYC) : 1;
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(PAR_HOLD_CYC);
   localparam logic [RPT_W-1:0]  RPT_LAST = RPT_W'(PAR_RPT_CYC - 1);

   logic              key_q, key_prev_q, block_q;
   logic [HOLD_W-1:0] hold_q;
   logic [RPT_W-1:0]  rpt_q;
   logic              run, rise, hold_hit, rpt_hit;

   always_comb begin
      run       = key_q & ~block_q & ~clr;
      rise      = key_q & ~key_prev_q;
      hold_hit  = (hold_q == HOLD_MAX - 1'b1);
      rpt_hit   = (hold_q == HOLD_MAX) && (rpt_q == RPT_LAST);
      pulse     = run & (rise | hold_hit | rpt_hit);
      key_edge  = key_q ^ key_prev_q;
      key_level = key_q;
   end

   // A clear blocks the key until it is released, so a held key never resumes by itself.
   always_ff @(posedge I_SYS_CLK or posedge I_EXT_RST) begin
      if (I_EXT_RST) begin
         key_q      <= 1'b0;
         key_prev_q <= 1'b0;
         block_q    <= 1'b0;
         hold_q     <= '0;
         rpt_q      <= '0;
      end else begin
         key_q      <= key;
         key_prev_q <= key_q;
         if (clr) begin
            block_q <= 1'b1;
         end else if (!key_q) begin
            block_q <= 1'b0;
         end
         if (!run) begin
            hold_q <= '0;
            rpt_q  <= '0;
         end else if (hold_q != HOLD_MAX) begin
            hold_q <= hold_q + 1'b1;
            rpt_q  <= '0;
         end else if (rpt_hit) begin
            rpt_q <= '0;
         end else begin
            rpt_q <= rpt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/time_adj_ctrl.sv
// Time-adjust controller: 1 s prescaler, MODE/UP/DOWN edit FSM, edit timeout and
// registered select / adjust / trigger / blink outputs for the sec-min-hour chain.
module time_adj_ctrl
   import time_adj_pkg::*;
#(
   parameter int unsigned PAR_TICK_DIV  = 50000000,
   parameter int unsigned PAR_HOLD_CYC  = 25000000,
   parameter int unsigned PAR_RPT_CYC   = 5000000,
   parameter int unsigned PAR_TIMEOUT_S = 10
) (
   input  logic            I_SYS_CLK,
   input  logic            I_EXT_RST,
   time_adj_ctrl_if.master bus
);

   localparam int unsigned PRE_W = $clog2(PAR_TICK_DIV);
   localparam int unsigned TMO_W = $clog2(PAR_TIMEOUT_S + 1);
   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(PAR_TICK_DIV - 1);
   localparam logic [PRE_W-1:0] BLINK_LIM = PRE_W'(PAR_TICK_DIV / 2);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(PAR_TIMEOUT_S - 1);

   state_e           state_q, state_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             tick;
   logic             mode_q, mode_prev_q, mode_rise;
   logic             up_p, dn_p, up_e, dn_e, up_l, dn_l;
   logic             in_edit, key_clr, activity;

   key_repeat #(
      .PAR_HOLD_CYC (PAR_HOLD_CYC),
      .PAR_RPT_CYC  (PAR_RPT_CYC)
   ) u_key_up (
      .I_SYS_CLK (I_SYS_CLK),
      .I_EXT_RST (I_EXT_RST),
      .key       (bus.I_KEY_UP),
      .clr       (key_clr),
      .pulse     (up_p),
      .key_edge  (up_e),
      .key_level (up_l)
   );

   key_repeat #(
      .PAR_HOLD_CYC (PAR_HOLD_CYC),
      .PAR_RPT_CYC  (PAR_RPT_CYC)
   ) u_key_down (
      .I_SYS_CLK (I_SYS_CLK),
      .I_EXT_RST (I_EXT_RST),
      .key       (bus.I_KEY_DOWN),
      .clr       (key_clr),
      .pulse     (dn_p),
      .key_edge  (dn_e),
      .key_level (dn_l)
   );

   always_comb begin
      tick      = (pre_q == PRE_LAST);
      pre_d     = tick ? '0 : pre_q + 1'b1;
      mode_rise = mode_q & ~mode_prev_q;
      in_edit   = (state_q != RUN);
      // MODE edge beats a coincident adjust; both keys down cancels both.
      key_clr   = ~in_edit | mode_rise | (up_l & dn_l);
      activity  = (mode_q ^ mode_prev_q) | up_e | dn_e | up_p | dn_p;
      state_d   = state_q;
      tmo_d     = tmo_q;
      if (mode_rise) begin
         state_d = next_state(state_q);
         tmo_d   = '0;
      end else if (in_edit) begin
         if (activity) begin
            tmo_d = '0;
         end else if (tick) begin
            if (tmo_q == TMO_LAST) begin
               state_d = RUN;
               tmo_d   = '0;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge I_SYS_CLK or posedge I_EXT_RST) begin
      if (I_EXT_RST) begin
         state_q        <= RUN;
         pre_q          <= '0;
         tmo_q          <= '0;
         mode_q         <= 1'b0;
         mode_prev_q    <= 1'b0;
         bus.O_TRIG_F   <= 1'b0;
         bus.O_ADJ_UP   <= 1'b0;
         bus.O_ADJ_DOWN <= 1'b0;
         bus.O_SEL_SEC  <= SEL_IDLE;
         bus.O_SEL_MIN  <= SEL_IDLE;
         bus.O_SEL_HOUR <= SEL_IDLE;
         bus.O_EDIT     <= 1'b0;
         bus.O_BLINK    <= 1'b1;
      end else begin
         state_q        <= state_d;
         pre_q          <= pre_d;
         tmo_q          <= tmo_d;
         mode_q         <= bus.I_KEY_MODE;
         mode_prev_q    <= mode_q;
         // Outputs follow state_d so selects, pulses and trigger change together.
         bus.O_TRIG_F   <= tick & (state_d == RUN);
         bus.O_ADJ_UP   <= up_p & ~dn_p & (state_d != RUN);
         bus.O_ADJ_DOWN <= dn_p & ~up_p & (state_d != RUN);
         bus.O_SEL_SEC  <= sel_for(state_d, SEC);
         bus.O_SEL_MIN  <= sel_for(state_d, MIN);
         bus.O_SEL_HOUR <= sel_for(state_d, HR);
         bus.O_EDIT     <= (state_d != RUN);
         bus.O_BLINK    <= (pre_d < BLINK_LIM);
      end
   end

endmodule
